// File: rtl/frame_rate_bcd_pkg.sv
// Shared definitions for the frame-rate display path: clock defaults, digit
// geometry, FSM states and the per-nibble double-dabble correction.
package frame_rate_bcd_pkg;
  localparam int CLK_HZ_DEF     = 4000000;
  localparam int REFRESH_HZ_DEF = 1000;
  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS     = 4;
  localparam int BCD_W          = DIGIT_W * NUM_DIGITS;
  localparam int BIN_W          = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Add 3 to every digit >= 5; digits never carry into their neighbour.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
        r[i*DIGIT_W +: DIGIT_W] = bcd[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
    end
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle, 14 steps,
// done pulses for one cycle 15 cycles after start with bcd valid.
module bin2bcd_serial
  import frame_rate_bcd_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);
  localparam int SH_W = BCD_W + BIN_W;
  localparam int IT_W = $clog2(BIN_W + 1);

  logic [SH_W-1:0] sh_q, sh_d;
  logic [IT_W-1:0] iter_q, iter_d;
  logic            done_q, done_d;

  always_comb begin
    sh_d   = sh_q;
    iter_d = iter_q;
    done_d = 1'b0;
    if (start) begin
      sh_d   = {{BCD_W{1'b0}}, bin};
      iter_d = IT_W'(BIN_W);
    end else if (iter_q != '0) begin
      sh_d   = {dd_adjust(sh_q[SH_W-1 -: BCD_W]), sh_q[BIN_W-1:0]} << 1;
      iter_d = iter_q - IT_W'(1);
      done_d = (iter_q == IT_W'(1));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_q   <= '0;
      iter_q <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      iter_q <= iter_d;
      done_q <= done_d;
    end
  end

  assign bcd  = sh_q[SH_W-1 -: BCD_W];
  assign done = done_q;
endmodule

// File: rtl/frame_rate_bcd.sv
// Counts synchronised FRAME_VALID rises per one-second gate, converts the
// count to BCD for the seven-segment driver and generates its refresh enable.
module frame_rate_bcd
  import frame_rate_bcd_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int REFRESH_HZ = REFRESH_HZ_DEF,
  parameter int MAX_COUNT  = 9999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_valid,
  output logic [15:0] values,
  output logic        en,
  output logic        ovf,
  output logic        busy
);
  localparam int DIV_TC = CLK_HZ / REFRESH_HZ - 1;
  localparam int GATE_W = $clog2(CLK_HZ);

  logic [2:0]        sync_q, sync_d;
  logic [11:0]       div_q, div_d;
  logic              en_q, en_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [BIN_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              snap_sat_q, snap_sat_d;
  logic              frame_start, gate_end;

  state_t            state_q;
  logic [BCD_W-1:0]  values_q;
  logic              ovf_q, busy_q;
  logic              conv_start, conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  assign frame_start = sync_q[1] & ~sync_q[2];
  assign gate_end    = (gate_q == GATE_W'(CLK_HZ - 1));

  always_comb begin
    sync_d     = {sync_q[1:0], frame_valid};
    div_d      = (div_q == 12'(DIV_TC)) ? 12'd0 : div_q + 12'd1;
    en_d       = (div_d == 12'(DIV_TC));
    gate_d     = gate_end ? '0 : gate_q + GATE_W'(1);
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    snap_sat_d = snap_sat_q;
    // An edge on the closing cycle opens the next window's count.
    if (gate_end) begin
      snap_sat_d = sat_q;
      cnt_d      = frame_start ? BIN_W'(1) : '0;
      sat_d      = 1'b0;
    end else if (frame_start) begin
      if (cnt_q >= BIN_W'(MAX_COUNT)) sat_d = 1'b1;
      else                            cnt_d = cnt_q + BIN_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= '0;
      div_q      <= '0;
      en_q       <= 1'b0;
      gate_q     <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      snap_sat_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      div_q      <= div_d;
      en_q       <= en_d;
      gate_q     <= gate_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      snap_sat_q <= snap_sat_d;
    end
  end

  // The converter captures the live count on the closing edge; that load is
  // the snapshot, so no separate count copy is kept.
  assign conv_start = gate_end && (state_q == IDLE);

  bin2bcd_serial u_conv (
    .CLK   (CLK),
    .RST   (RST),
    .start (conv_start),
    .bin   (cnt_q),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // The result lands on the edge that enters DONE; values moves nowhere else.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      values_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gate_end) begin
          state_q <= CONVERT;
          busy_q  <= 1'b1;
        end
        CONVERT: if (conv_done) begin
          state_q  <= DONE;
          values_q <= conv_bcd;
          ovf_q    <= snap_sat_q;
          busy_q   <= 1'b0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign values = values_q;
  assign en     = en_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_frame_rate_bcd.sv
// Bench: two tops (normal and MAX_COUNT=20) share frame_valid; a per-window
// frame tally predicts display, ovf, busy and en every cycle.
module tb_frame_rate_bcd;
  localparam int CLK_HZ = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int PER = CLK_HZ / REFRESH_HZ;
  localparam int LAT = 16;
  localparam int MAX_A = 9999;
  localparam int MAX_B = 20;

  logic CLK = 0, RST = 0, frame_valid = 0;
  logic [15:0] values, values_s;
  logic en, ovf, busy, en_s, ovf_s, busy_s;
  logic cv_start = 0;
  logic [13:0] cv_bin = 0;
  logic [15:0] cv_bcd;
  logic cv_done;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  bit mon_en = 0;
  int wcnt[0:15];

  frame_rate_bcd #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .MAX_COUNT(MAX_A)) dut (
    .CLK(CLK), .RST(RST), .frame_valid(frame_valid), .values(values),
    .en(en), .ovf(ovf), .busy(busy));
  frame_rate_bcd #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .MAX_COUNT(MAX_B)) dut_sat (
    .CLK(CLK), .RST(RST), .frame_valid(frame_valid), .values(values_s),
    .en(en_s), .ovf(ovf_s), .busy(busy_s));
  bin2bcd_serial cv (
    .CLK(CLK), .RST(RST), .start(cv_start), .bin(cv_bin), .bcd(cv_bcd), .done(cv_done));

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (RST) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // cyc = k means we are just after the k-th edge since reset release.
  always @(negedge CLK) if (mon_en && !RST) begin
    int k, w, n, r;
    logic [15:0] ev, evs;
    logic eo, eos, eb;
    k = cyc; ev = 0; evs = 0; eo = 0; eos = 0; eb = 0;
    if (k >= CLK_HZ + LAT - 1) begin
      w = (k - (CLK_HZ + LAT - 1)) / CLK_HZ;
      n = wcnt[w];
      ev  = to_bcd(n > MAX_A ? MAX_A : n);  eo  = (n > MAX_A);
      evs = to_bcd(n > MAX_B ? MAX_B : n);  eos = (n > MAX_B);
    end
    if (k >= CLK_HZ) begin
      r = (k - (CLK_HZ - 1)) % CLK_HZ;
      eb = (r >= 1 && r <= LAT - 1);
    end
    chk("en", en, (k % PER) == PER - 1);
    chk("en_sat", en_s, (k % PER) == PER - 1);
    chk("busy", busy, eb);
    chk("values", values, ev);
    chk("ovf", ovf, eo);
    chk("values_sat", values_s, evs);
    chk("ovf_sat", ovf_s, eos);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic pulse();
    wcnt[(cyc + 3) / CLK_HZ]++;
    frame_valid = 1; tick(5);
    frame_valid = 0; tick(10);
  endtask

  task automatic train(input int start, input int n, input int gap_max);
    wait_cyc(start);
    repeat (n) begin pulse(); tick($urandom_range(0, gap_max)); end
  endtask

  task automatic conv(input int v);
    cv_bin = 14'(v); cv_start = 1; tick(1);
    cv_start = 0; tick(13);
    chk("cv_done_early", cv_done, 0); tick(1);
    chk("cv_done", cv_done, 1);
    chk("cv_bcd", cv_bcd, to_bcd(v)); tick(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int vals[7];
    vals = '{0, 9, 10, 99, 100, 1234, 9999};
    foreach (wcnt[i]) wcnt[i] = 0;
    #2 RST = 1; #1;
    chk("rst_values", values, 0); chk("rst_en", en, 0);
    chk("rst_ovf", ovf, 0);       chk("rst_busy", busy, 0);
    repeat (3) @(negedge CLK);
    #2 RST = 0; mon_en = 1;

    train(50, 37, 0);                       // window 0: 37 frames
    wait_cyc(CLK_HZ + LAT - 2);
    chk("t2_busy_last", busy, 1); chk("t2_hold", values, 16'h0000);
    tick(1);
    chk("t2_values", values, 16'h0037); chk("t2_ovf", ovf, 0); chk("t2_busy_off", busy, 0);

    train(1050, 12, 0);                     // window 1: 12 frames ...
    wait_cyc(1997); pulse();                // ... plus an edge on gate_end
    wait_cyc(2015);
    chk("t3_values", values, 16'h0012);
    train(2100, 1, 0);
    wait_cyc(3015);
    chk("t3_next", values, 16'h0002);

    train(3050, 25, 1);                     // window 3: saturates dut_sat
    wait_cyc(4015);
    chk("t4_values", values, 16'h0025); chk("t4_sat", values_s, 16'h0020);
    chk("t4_ovf_sat", ovf_s, 1);
    train(4050, 3, 0);
    wait_cyc(5015);
    chk("t4_after", values_s, 16'h0003); chk("t4_ovf_clr", ovf_s, 0);

    for (int w = 5; w < 9; w++)
      train(w * CLK_HZ + 20 + $urandom_range(0, 50), $urandom_range(0, 50), 2);
    train(9050, 23, 0);
    wait_cyc(10015);
    chk("pre_rst_values", values, 16'h0023); chk("pre_rst_ovf", ovf_s, 1);

    wait_cyc(11005);                        // 5 cycles into CONVERT
    chk("pre_rst_busy", busy, 1);
    RST = 1; #1;
    chk("t5_values", values, 0); chk("t5_values_sat", values_s, 0);
    chk("t5_ovf", ovf_s, 0);     chk("t5_busy", busy, 0);
    foreach (wcnt[i]) wcnt[i] = 0;
    repeat (3) @(negedge CLK);
    #2 RST = 0;
    train(100, 5, 0);
    wait_cyc(CLK_HZ - 1);
    chk("t5_no_done", values, 0);
    wait_cyc(CLK_HZ + LAT + 14);
    chk("t5_values_new", values, 16'h0005);

    mon_en = 0;
    foreach (vals[i]) conv(vals[i]);
    repeat (6) conv($urandom_range(0, 9999));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_rate_bcd.md
Name: frame_rate_bcd

Overview:
- Measures the camera frame rate and presents it as four BCD digits on `values[15:0]`.
- Also generates the 1 kHz, single-cycle refresh enable `en`.
- Sits directly upstream of the four-digit seven-segment driver and feeds both of that driver's non-clock inputs.
- Frame starts are rising edges of the sensor FRAME_VALID, synchronised into the 4 MHz display clock domain.

Parameters:
- CLK_HZ, 4000000, CLK frequency in Hz. Sets the gate window length in cycles.
- REFRESH_HZ, 1000, rate of `en` pulses. Divider terminal count is CLK_HZ/REFRESH_HZ - 1.
- MAX_COUNT, 9999, saturation value of the frame counter (four decimal digits).

Ports:
- CLK  input  1  4 MHz display clock.
- RST  input  1  asynchronous, active-high reset.
- frame_valid  input  1  sensor FRAME_VALID, asynchronous to CLK.
- values  output  16  BCD digits; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- en  output  1  one-CLK-cycle pulse every CLK_HZ/REFRESH_HZ cycles.
- ovf  output  1  high while the displayed result came from a saturated count.
- busy  output  1  high while a BCD conversion is in progress.

Behaviour:
- Reset (async, RST=1): values=16'h0000, en=0, ovf=0, busy=0.
  - Sync flops, gate counter, frame counter and refresh divider all clear to 0.
  - FSM goes to IDLE.
  - Deasserting RST mid-conversion resumes from IDLE. Any partial conversion is discarded.
- Synchroniser and edge detect:
  - frame_valid passes through 2 flops, plus a third flop for edge detect.
  - frame_start = s2 & ~s3.
  - Latency from a frame_valid rise to frame_start is 2-3 CLK cycles.
- Refresh divider:
  - 12-bit counter counts 0..CLK_HZ/REFRESH_HZ-1 and wraps.
  - en is registered and is 1 on the cycle the counter holds terminal count.
  - Free-running and independent of the FSM. First pulse on cycle 4000 after reset release (default parameters).
- Gate counter:
  - Counts 0..CLK_HZ-1 and wraps. gate_end=1 on the terminal cycle.
- Frame counter (14 bits):
  - Increments on frame_start and saturates at MAX_COUNT. Saturation sets an internal sat flag.
  - On gate_end: latch snapshot=count and snap_sat=sat. Then count <= frame_start ? 1 : 0 and sat <= 0.
  - A frame edge coinciding with gate_end is credited to the new window, never lost or counted twice.
- FSM IDLE / CONVERT / DONE:
  - IDLE -> CONVERT on gate_end. Load the shift register {16'h0, snapshot}, set the iteration count to 14, and set busy=1.
  - CONVERT: one double-dabble iteration per cycle. First add 3 to each BCD nibble >= 5, then shift left by 1. After the 14th iteration go to DONE.
  - DONE (1 cycle): values <= BCD result, ovf <= snap_sat, busy <= 0. Then back to IDLE.
  - values changes only in DONE, so the display never shows a partially converted value.
  - Total latency is 16 cycles: gate_end to values update.
  - A gate_end arriving while not in IDLE cannot happen with legal parameters (CLK_HZ >> 16). The FSM ignores it; the snapshot is still taken.
- All arithmetic is unsigned. BCD add-3 is done per nibble with no inter-nibble carry.

Decomposition:
- Shared include file `display_defs.vh`:
  - CLK_HZ and REFRESH_HZ defaults.
  - FSM state localparams (IDLE=2'd0, CONVERT=2'd1, DONE=2'd2).
  - BCD digit width (4) and digit count (4).
- One sub-module: `bin2bcd_serial`.
  - Ports: CLK, RST, start, bin[13:0], bcd[15:0], done.
  - Contains the CONVERT iteration logic and the iteration counter.
  - The top level keeps the synchroniser, divider, gate counter and the IDLE/DONE handshake.

Test Plan:
- Bench parameters: CLK_HZ=1000, REFRESH_HZ=100.
- Test 1, refresh: hold frame_valid=0 and release RST -> en pulses on cycles 10, 20, 30..., 1 cycle wide each; values stays 16'h0000.
- Test 2, basic count: 37 frame_valid pulses (5 high, 10 low) inside one gate -> 16 cycles after gate_end, values=16'h0037, ovf=0, busy high for exactly 15 cycles.
- Test 3, boundary edge: a frame_start lands exactly on a gate_end with 12 frames already counted -> this window shows 16'h0012; the next window counts that edge (1 more pulse gives 16'h0002).
- Test 4, saturation: MAX_COUNT=20, 25 frames in one gate -> values=16'h0020, ovf=1; next gate with 3 frames -> values=16'h0003, ovf=0.
- Test 5, reset mid-conversion: assert RST 5 cycles into CONVERT -> values, ovf and busy go to 0 asynchronously; after release, no DONE update occurs until the next gate_end.
- Test 6, converter sweep: drive bin2bcd_serial standalone with 0, 9, 10, 99, 100, 1234, 9999 -> bcd 16'h0000, 0009, 0010, 0099, 0100, 1234, 9999, with done 15 cycles after start.
